// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, PC increment, fetch-queue entry.
package mips_pkg;
  localparam int          DATA_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush, head output and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_do_pop  = i_pop & (r_cnt != '0);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & ((r_cnt != C_FULL) | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '{default: '0};
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop)
        r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, memory requests, prefetch queue, redirect flush.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $bits(fetch_entry_t);
  localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);

  logic [31:0]   r_fpc;
  logic [31:0]   r_req_addr;
  logic          r_inflight;
  logic          r_kill;
  logic          r_started;

  logic [AW:0]   w_count;
  logic [AW+1:0] w_occ;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_head_bits;
  fetch_entry_t  w_head;

  // Credit check: queued entries plus the one in flight must leave room.
  assign w_occ  = {1'b0, w_count} + {{(AW+1){1'b0}}, r_inflight};
  assign w_req  = r_started & ~i_redirect & (w_occ < C_DEPTH);
  assign w_push = r_inflight & ~r_kill;
  assign w_pop  = o_valid & i_ready;
  assign w_din  = {r_req_addr, i_imem_rdata};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fpc      <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_started  <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (i_redirect) begin
        r_fpc      <= {i_redirect_pc[31:2], 2'b00};
        r_kill     <= r_inflight;
        r_inflight <= 1'b0;
      end else begin
        r_kill     <= 1'b0;
        r_inflight <= w_req;
        if (w_req) begin
          r_fpc      <= r_fpc + PC_STEP;
          r_req_addr <= r_fpc;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_din   (w_din),
    .o_head  (w_head_bits),
    .o_count (w_count)
  );

  assign w_head      = w_head_bits;
  assign o_valid     = (w_count != '0);
  assign o_instr     = w_head.instr;
  assign o_instr_pc  = w_head.pc;
  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fpc;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the MIPS core. It owns the fetch PC, issues word requests to the synchronous instruction memory, and buffers the returned instructions with their PCs in a small prefetch queue. The decode stage drains the queue through a valid/ready handshake. A branch or jump redirect from execute flushes the queue and restarts fetch at a new address.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset.
- DEPTH, 4: queue entries; a power of two, at least 2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- o_imem_req  out  1  fetch request this cycle.
- o_imem_addr  out  32  word address of the request (bits [1:0] always 0).
- i_imem_rdata  in  32  instruction word, valid exactly one cycle after an accepted request. Memory always accepts.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  32  new fetch address, sampled when i_redirect=1.
- o_valid  out  1  queue head holds an instruction.
- o_instr  out  32  instruction at queue head.
- o_instr_pc  out  32  PC of o_instr.
- i_ready  in  1  decode accepts the head; a transfer happens when o_valid and i_ready are both high.

## Operation
- **State**
  - fpc: fetch PC, 32 bits.
  - inflight: 1 bit, set in the cycle after a request.
  - kill: 1 bit, drop the in-flight response.
  - started: 1 bit, clear during reset, set on the first edge after reset release.
  - Queue of DEPTH entries, each {pc, instr}, with an occupancy count.
- **Request**
  - o_imem_req = started & !i_redirect & (occupancy + inflight < DEPTH).
  - o_imem_addr = fpc.
  - On an issued request: fpc <= fpc + 4, inflight <= 1, and the request address is captured for the response.
- **Response**
  - When inflight=1 and kill=0, push {captured address, i_imem_rdata} into the queue.
  - When kill=1, discard the response.
- **Pop**
  - On a transfer, the head advances.
  - Push and pop in the same cycle leave occupancy unchanged.
- **Redirect**
  - Actions on the edge where i_redirect=1:
    - Queue cleared.
    - fpc <= {i_redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
    - kill <= inflight.
    - No request is issued in the redirect cycle.
  - A transfer in the same cycle as a redirect still counts as consumed by decode; the flush happens after it.
  - Back-to-back redirects: the last one wins.
- **Wrap-around**: fpc = 32'hFFFF_FFFC plus 4 gives 32'h0000_0000, with no flag.
- **Full queue**: requests stall. No instruction is ever dropped or overwritten unless a redirect flushes it.

## Timing
- **Reset values**
  - o_imem_req=0, o_imem_addr=RESET_PC, o_valid=0, o_instr=0, o_instr_pc=0.
  - fpc=RESET_PC; inflight, kill and started all 0.
- **Reset mid-operation** forces all of the above immediately (asynchronously). Queue contents and any pending response are lost.
- **Startup**: first request in the cycle after the first rising edge following reset release.
- **Latency**: request at edge k, data on i_imem_rdata in cycle k+1, push at edge k+1, o_valid high from k+1. Request to o_valid is 1 cycle.
- **Redirect latency**: redirect at edge r, first new request in cycle r+1, first o_valid of the new stream after edge r+2.
- **Throughput**: one instruction per cycle sustained while i_ready=1 and DEPTH≥3.
- **Output timing**: o_valid, o_instr and o_instr_pc are driven from registered queue storage, with no combinational path from i_ready. o_imem_req depends combinationally on i_redirect only.

## Structure
- **Shared package mips_pkg**:
  - Constants DATA_W=32 and PC_STEP=4.
  - The fetch-entry typedef {pc, instr}.
- **Sub-module fetch_fifo**: synchronous FIFO.
  - Parameters: DEPTH and entry width.
  - Ports: push, pop, flush (flush takes priority over push), a head output, and a count.
- **fetch_unit top**: holds fpc, inflight, kill and started, plus the credit comparison.

## Test plan
- **Reset then run** (RESET_PC=0, i_ready=1, memory returns addr^32'hA5A5_0000):
  - Requests go to 0, 4, 8, …
  - o_valid rises 1 cycle after the first request.
  - o_instr_pc increments by 4 every cycle with the matching data.
- **Backpressure**: hold i_ready=0.
  - Exactly DEPTH=4 entries fill, then o_imem_req stays 0.
  - After releasing i_ready: PCs 0, 4, 8, 12, 16 appear in order with no gaps or duplicates.
- **Redirect with a request in flight**: i_redirect=1 with i_redirect_pc=32'h0000_0103 one cycle after a request to 8.
  - The response for 8 never appears.
  - The next request goes to 32'h100.
  - The next o_instr_pc is 32'h100.
- **Redirect with simultaneous transfer**: the head (pc=4) is accepted in the same cycle as a redirect.
  - Decode receives pc=4 exactly once.
  - No entry older than the redirect target is presented afterwards.
- **Wrap-around**: redirect to 32'hFFFF_FFF8.
  - o_instr_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- **Asynchronous reset mid-stream**: assert i_rst_n=0 between clock edges with 3 entries queued.
  - o_valid and o_imem_req drop immediately.
  - After release, fetch restarts at RESET_PC.
